// File: rtl/cci_mpf_shim_pipe_qlp.sv
// rtl/cci_mpf_shim_pipe_qlp.sv - QLP-side pipeline shim: per-channel TX FIFO with bypass, fixed-latency RX delay line.
module cci_mpf_shim_pipe_qlp #(
    parameter int NUM_CHAN  = 2,
    parameter int TX_W      = 600,
    parameter int RX_W      = 600,
    parameter int RX_STAGES = 1,
    parameter int TX_DEPTH  = 8,
    parameter int TX_SLACK  = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_CHAN-1:0]            tx_valid_in,
    input  logic [NUM_CHAN-1:0][TX_W-1:0]  tx_in,
    output logic [NUM_CHAN-1:0]            tx_almfull_out,
    output logic [NUM_CHAN-1:0]            tx_valid_out,
    output logic [NUM_CHAN-1:0][TX_W-1:0]  tx_out,
    input  logic [NUM_CHAN-1:0]            tx_almfull_in,
    input  logic [NUM_CHAN-1:0]            rx_valid_in,
    input  logic [NUM_CHAN-1:0][RX_W-1:0]  rx_in,
    output logic [NUM_CHAN-1:0]            rx_valid_out,
    output logic [NUM_CHAN-1:0][RX_W-1:0]  rx_out,
    output logic [NUM_CHAN-1:0]            tx_overflow
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(TX_DEPTH - TX_SLACK);

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_tx
        logic [TX_W-1:0] mem [TX_DEPTH];
        logic [PW-1:0]   rd_ptr;
        logic [PW-1:0]   wr_ptr;
        logic [CW-1:0]   count;
        logic            valid_q;
        logic            ovf_q;
        logic [TX_W-1:0] out_q;
        logic            empty, full, deq, byp, enq, drop;

        // Bypass only when nothing is queued, so order is preserved.
        always_comb begin
            empty = (count == '0);
            full  = (count == FULL_CNT);
            deq   = !empty && !tx_almfull_in[c];
            byp   = empty && !tx_almfull_in[c] && tx_valid_in[c];
            enq   = tx_valid_in[c] && !byp && (!full || deq);
            drop  = tx_valid_in[c] && !byp && full && !deq;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                if (enq && !deq)
                    count <= count + 1'b1;
                else if (!enq && deq)
                    count <= count - 1'b1;
                valid_q <= deq || byp;
                if (drop) ovf_q <= 1'b1;
            end
        end

        // Payload storage carries no reset; it is qualified by the valids above.
        always_ff @(posedge clk) begin
            if (enq) mem[wr_ptr] <= tx_in[c];
            if (deq)
                out_q <= mem[rd_ptr];
            else if (byp)
                out_q <= tx_in[c];
        end

        assign tx_almfull_out[c] = (count >= AF_CNT);
        assign tx_valid_out[c]   = valid_q;
        assign tx_out[c]         = out_q;
        assign tx_overflow[c]    = ovf_q;
    end

    logic [NUM_CHAN-1:0]           rv_q [RX_STAGES];
    logic [NUM_CHAN-1:0][RX_W-1:0] rd_q [RX_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < RX_STAGES; s++) rv_q[s] <= '0;
        end else begin
            rv_q[0] <= rx_valid_in;
            for (int s = 1; s < RX_STAGES; s++) rv_q[s] <= rv_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        rd_q[0] <= rx_in;
        for (int s = 1; s < RX_STAGES; s++) rd_q[s] <= rd_q[s-1];
    end

    assign rx_valid_out = rv_q[RX_STAGES-1];
    assign rx_out       = rd_q[RX_STAGES-1];

endmodule

// File: tb/tb_cci_mpf_shim_pipe_qlp.sv
// tb/tb_cci_mpf_shim_pipe_qlp.sv - directed self-checking bench for cci_mpf_shim_pipe_qlp.
module tb_cci_mpf_shim_pipe_qlp;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        tx_valid_in, tx_almfull_in, rx_valid_in;
    logic [1:0][15:0]  tx_in, rx_in;
    logic [1:0]        tx_almfull_out, tx_valid_out, rx_valid_out, tx_overflow;
    logic [1:0][15:0]  tx_out, rx_out;

    logic [1:0]        w_valid_in, w_almfull_in, w_rx_valid_in;
    logic [1:0][15:0]  w_in, w_rx_in;
    logic [1:0]        w_almfull_out, w_valid_out, w_rx_valid_out, w_overflow;
    logic [1:0][15:0]  w_out, w_rx_out;

    int total = 0;
    int passed = 0;

    cci_mpf_shim_pipe_qlp #(
        .NUM_CHAN(2), .TX_W(16), .RX_W(16), .RX_STAGES(3), .TX_DEPTH(8), .TX_SLACK(4)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .tx_valid_in(tx_valid_in), .tx_in(tx_in), .tx_almfull_out(tx_almfull_out),
        .tx_valid_out(tx_valid_out), .tx_out(tx_out), .tx_almfull_in(tx_almfull_in),
        .rx_valid_in(rx_valid_in), .rx_in(rx_in), .rx_valid_out(rx_valid_out),
        .rx_out(rx_out), .tx_overflow(tx_overflow)
    );

    cci_mpf_shim_pipe_qlp #(
        .NUM_CHAN(2), .TX_W(16), .RX_W(16), .RX_STAGES(1), .TX_DEPTH(4), .TX_SLACK(2)
    ) u_wrap (
        .clk(clk), .reset_n(reset_n),
        .tx_valid_in(w_valid_in), .tx_in(w_in), .tx_almfull_out(w_almfull_out),
        .tx_valid_out(w_valid_out), .tx_out(w_out), .tx_almfull_in(w_almfull_in),
        .rx_valid_in(w_rx_valid_in), .rx_in(w_rx_in), .rx_valid_out(w_rx_valid_out),
        .rx_out(w_rx_out), .tx_overflow(w_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tx_valid_in = '0; tx_almfull_in = '0; rx_valid_in = '0; tx_in = '0; rx_in = '0;
        w_valid_in = '0; w_almfull_in = '0; w_rx_valid_in = '0; w_in = '0; w_rx_in = '0;
        reset_n = 1'b0;
        repeat (2) step();
        total++; if (tx_valid_out !== 2'b00) $display("FAIL reset_tx_valid got=%b exp=00", tx_valid_out); else passed++;
        total++; if (rx_valid_out !== 2'b00) $display("FAIL reset_rx_valid got=%b exp=00", rx_valid_out); else passed++;
        total++; if (tx_almfull_out !== 2'b00) $display("FAIL reset_almfull got=%b exp=00", tx_almfull_out); else passed++;
        total++; if (tx_overflow !== 2'b00) $display("FAIL reset_overflow got=%b exp=00", tx_overflow); else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_bypass();
        tx_valid_in[0] = 1'b1; tx_in[0] = 16'h00A5;
        step();
        tx_valid_in[0] = 1'b0;
        total++; if (tx_valid_out[0] !== 1'b1) $display("FAIL bypass_valid got=%b exp=1", tx_valid_out[0]); else passed++;
        total++; if (tx_out[0] !== 16'h00A5) $display("FAIL bypass_data got=%h exp=00a5", tx_out[0]); else passed++;
        total++; if (tx_almfull_out[0] !== 1'b0) $display("FAIL bypass_almfull got=%b exp=0", tx_almfull_out[0]); else passed++;
        step();
        total++; if (tx_valid_out[0] !== 1'b0) $display("FAIL bypass_idle_valid got=%b exp=0", tx_valid_out[0]); else passed++;
        total++; if (tx_out[0] !== 16'h00A5) $display("FAIL bypass_hold_data got=%h exp=00a5", tx_out[0]); else passed++;
    endtask

    task automatic test_backpressure();
        tx_almfull_in[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_valid_in[1] = 1'b1; tx_in[1] = 16'h0100 + 16'(i);
            step();
            total++; if (tx_almfull_out[1] !== (i == 3)) $display("FAIL bp_almfull_%0d got=%b exp=%b", i, tx_almfull_out[1], (i == 3)); else passed++;
            total++; if (tx_valid_out[1] !== 1'b0) $display("FAIL bp_stall_valid_%0d got=%b exp=0", i, tx_valid_out[1]); else passed++;
        end
        tx_valid_in[1] = 1'b0; tx_almfull_in[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (tx_valid_out[1] !== 1'b1) $display("FAIL bp_drain_valid_%0d got=%b exp=1", i, tx_valid_out[1]); else passed++;
            total++; if (tx_out[1] !== 16'h0100 + 16'(i)) $display("FAIL bp_drain_data_%0d got=%h exp=%h", i, tx_out[1], 16'h0100 + 16'(i)); else passed++;
        end
        step();
        total++; if (tx_valid_out[1] !== 1'b0) $display("FAIL bp_after_valid got=%b exp=0", tx_valid_out[1]); else passed++;
        total++; if (tx_almfull_out[1] !== 1'b0) $display("FAIL bp_after_almfull got=%b exp=0", tx_almfull_out[1]); else passed++;
    endtask

    task automatic test_overflow();
        tx_almfull_in[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tx_valid_in[0] = 1'b1; tx_in[0] = 16'h0200 + 16'(i);
            step();
            if (i == 7) begin
                total++; if (tx_overflow[0] !== 1'b0) $display("FAIL ovf_at_full got=%b exp=0", tx_overflow[0]); else passed++;
                total++; if (tx_almfull_out[0] !== 1'b1) $display("FAIL ovf_almfull got=%b exp=1", tx_almfull_out[0]); else passed++;
            end
        end
        tx_valid_in[0] = 1'b0;
        total++; if (tx_overflow[0] !== 1'b1) $display("FAIL ovf_set got=%b exp=1", tx_overflow[0]); else passed++;
        total++; if (tx_overflow[1] !== 1'b0) $display("FAIL ovf_ch1 got=%b exp=0", tx_overflow[1]); else passed++;
        tx_almfull_in[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            total++; if (tx_valid_out[0] !== 1'b1) $display("FAIL ovf_drain_valid_%0d got=%b exp=1", i, tx_valid_out[0]); else passed++;
            total++; if (tx_out[0] !== 16'h0200 + 16'(i)) $display("FAIL ovf_drain_data_%0d got=%h exp=%h", i, tx_out[0], 16'h0200 + 16'(i)); else passed++;
        end
        step();
        total++; if (tx_valid_out[0] !== 1'b0) $display("FAIL ovf_dropped_valid got=%b exp=0", tx_valid_out[0]); else passed++;
        total++; if (tx_overflow[0] !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", tx_overflow[0]); else passed++;
    endtask

    task automatic test_rx_latency();
        logic exp_v;
        for (int t = 0; t < 11; t++) begin
            exp_v = (t == 3) || (t == 4) || (t == 8);
            total++; if (rx_valid_out[0] !== exp_v) $display("FAIL rx_valid_t%0d got=%b exp=%b", t, rx_valid_out[0], exp_v); else passed++;
            if (exp_v) begin
                total++; if (rx_out[0] !== 16'h0300 + 16'(t - 3)) $display("FAIL rx_data_t%0d got=%h exp=%h", t, rx_out[0], 16'h0300 + 16'(t - 3)); else passed++;
            end
            total++; if (rx_valid_out[1] !== 1'b0) $display("FAIL rx_ch1_t%0d got=%b exp=0", t, rx_valid_out[1]); else passed++;
            rx_valid_in[0] = (t == 0) || (t == 1) || (t == 5);
            rx_in[0] = 16'h0300 + 16'(t);
            step();
        end
        rx_valid_in = '0;
    endtask

    task automatic test_wrap();
        logic [15:0] exp_q[$];
        logic [15:0] e;
        int sent = 0;
        int rcv = 0;
        int cyc = 0;
        while (rcv < 20 && cyc < 300) begin
            w_almfull_in[0] = ((cyc / 3) % 2) == 1;
            if (sent < 20 && !w_almfull_out[0]) begin
                w_valid_in[0] = 1'b1;
                w_in[0] = 16'h0500 + 16'(sent);
                exp_q.push_back(16'h0500 + 16'(sent));
                sent++;
            end else begin
                w_valid_in[0] = 1'b0;
            end
            step();
            cyc++;
            if (w_valid_out[0]) begin
                if (exp_q.size() == 0) begin
                    total++; $display("FAIL wrap_unexpected got=%h exp=none", w_out[0]);
                end else begin
                    e = exp_q.pop_front();
                    total++; if (w_out[0] !== e) $display("FAIL wrap_order_%0d got=%h exp=%h", rcv, w_out[0], e); else passed++;
                end
                rcv++;
            end
        end
        w_valid_in = '0; w_almfull_in = '0;
        total++; if (rcv !== 20) $display("FAIL wrap_count got=%0d exp=20", rcv); else passed++;
        total++; if (w_overflow !== 2'b00) $display("FAIL wrap_overflow got=%b exp=00", w_overflow); else passed++;
    endtask

    task automatic test_reset_midflight();
        tx_almfull_in[0] = 1'b1; tx_almfull_in[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_valid_in[0] = 1'b1; tx_in[0] = 16'h0400 + 16'(i);
            tx_valid_in[1] = (i == 4); tx_in[1] = 16'h04BB;
            step();
        end
        tx_valid_in = '0;
        total++; if (tx_almfull_out[0] !== 1'b1) $display("FAIL rst_pre_almfull got=%b exp=1", tx_almfull_out[0]); else passed++;
        total++; if (tx_valid_out[1] !== 1'b1) $display("FAIL rst_pre_valid1 got=%b exp=1", tx_valid_out[1]); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (tx_valid_out !== 2'b00) $display("FAIL rst_async_valid got=%b exp=00", tx_valid_out); else passed++;
        total++; if (tx_almfull_out !== 2'b00) $display("FAIL rst_async_almfull got=%b exp=00", tx_almfull_out); else passed++;
        total++; if (tx_overflow !== 2'b00) $display("FAIL rst_async_overflow got=%b exp=00", tx_overflow); else passed++;
        step();
        reset_n = 1'b1;
        tx_almfull_in = '0;
        tx_valid_in[0] = 1'b1; tx_in[0] = 16'h04AA;
        step();
        tx_valid_in = '0;
        total++; if (tx_valid_out[0] !== 1'b1) $display("FAIL rst_first_edge_valid got=%b exp=1", tx_valid_out[0]); else passed++;
        total++; if (tx_out[0] !== 16'h04AA) $display("FAIL rst_first_edge_data got=%h exp=04aa", tx_out[0]); else passed++;
        for (int i = 0; i < 8; i++) begin
            step();
            total++; if (tx_valid_out[0] !== 1'b0) $display("FAIL rst_stale_emit_%0d got=%b data=%h exp=0", i, tx_valid_out[0], tx_out[0]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_backpressure();
        test_overflow();
        test_rx_latency();
        test_wrap();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
